quad_step_gen_amisha: RTL and testbench

Quadrature (A/B) decoder that produces the en/up step interface consumed by our universal up/down binary counter.
- Synchronises and deglitches two asynchronous encoder lines.
- Decodes 4x Gray transitions into single-cycle step pulses plus a direction level.
- Flags and counts illegal double transitions.
- Sits between the board encoder pins and the position counter.

---
 rtl/quad_pkg_amisha.sv | 49 ++++
 rtl/quad_sync_filt_amisha.sv | 47 ++++
 rtl/quad_step_gen_amisha.sv | 108 ++++++++++
 tb/tb_quad_step_gen_amisha.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg_amisha.sv
// Shared types and helpers for the quadrature step generator.
// Holds the {A,B} state encoding and the transition classifier.
package quad_pkg_amisha;

    typedef logic [1:0] qstate_t;

    localparam qstate_t ST_00 = 2'b00;
    localparam qstate_t ST_01 = 2'b01;
    localparam qstate_t ST_11 = 2'b11;
    localparam qstate_t ST_10 = 2'b10;

    typedef enum logic [1:0] {
        TR_NONE,
        TR_UP,
        TR_DOWN,
        TR_ILL
    } qtrans_t;

    // Successor of a state in the up (forward) Gray sequence.
    function automatic qstate_t next_up(input qstate_t s);
        qstate_t r;
        r = ST_00;
        unique case (s)
            ST_00:   r = ST_01;
            ST_01:   r = ST_11;
            ST_11:   r = ST_10;
            default: r = ST_00;
        endcase
        return r;
    endfunction

    function automatic qtrans_t classify(
        input qstate_t prev,
        input qstate_t cur
    );
        qtrans_t t;
        t = TR_ILL;
        if (cur == prev)
            t = TR_NONE;
        else if (cur == next_up(prev))
            t = TR_UP;
        else if (prev == next_up(cur))
            t = TR_DOWN;
        else
            t = TR_ILL;
        return t;
    endfunction

endpackage

// File: rtl/quad_sync_filt_amisha.sv
// 2-flop synchroniser plus FILT_LEN-deep history and stable flag.
// Ports: clk/reset, din (async), dout (newest history), stable_amisha.
module quad_sync_filt_amisha #(
    parameter int W_amisha        = 2,
    parameter int FILT_LEN_amisha = 4
) (
    input  logic                clk_amisha,
    input  logic                reset_amisha,
    input  logic [W_amisha-1:0] din_amisha,
    output logic [W_amisha-1:0] dout_amisha,
    output logic                stable_amisha
);

    logic [W_amisha-1:0] s1;
    logic [W_amisha-1:0] s2;
    logic [W_amisha-1:0] h [FILT_LEN_amisha];
    // One bit per pipeline stage that holds a real post-reset sample,
    // so reset zeros in the history never count as a stable level.
    logic [FILT_LEN_amisha+1:0] vld;

    always_ff @(posedge clk_amisha) begin
        if (!reset_amisha) begin
            s1  <= '0;
            s2  <= '0;
            vld <= '0;
            for (int i = 0; i < FILT_LEN_amisha; i++)
                h[i] <= '0;
        end else begin
            s1   <= din_amisha;
            s2   <= s1;
            h[0] <= s2;
            for (int i = 1; i < FILT_LEN_amisha; i++)
                h[i] <= h[i-1];
            vld <= {vld[FILT_LEN_amisha:0], 1'b1};
        end
    end

    always_comb begin
        stable_amisha = &vld;
        for (int i = 1; i < FILT_LEN_amisha; i++)
            if (h[i] != h[0])
                stable_amisha = 1'b0;
    end

    assign dout_amisha = h[0];

endmodule

// File: rtl/quad_step_gen_amisha.sv
// Quadrature A/B decoder: filtered 4x decode to en/up steps, error count.
// Ports: a/b pins, en_in, clr_err -> en, up, err, err_cnt, ab. Optional
// QUAD_POS_CNT_EN adds syn_clr, pos, max_tick, min_tick.
import quad_pkg_amisha::*;

module quad_step_gen_amisha #(
    parameter int FILT_LEN_amisha = 4,
    parameter int ERR_W_amisha    = 4,
    parameter int N_amisha        = 8
) (
    input  logic                    clk_amisha,
    input  logic                    reset_amisha,
    input  logic                    a_amisha,
    input  logic                    b_amisha,
    input  logic                    en_in_amisha,
    input  logic                    clr_err_amisha,
    output logic                    en_amisha,
    output logic                    up_amisha,
    output logic                    err_amisha,
    output logic [ERR_W_amisha-1:0] err_cnt_amisha,
`ifdef QUAD_POS_CNT_EN
    input  logic                    syn_clr_amisha,
    output logic [N_amisha-1:0]     pos_amisha,
    output logic                    max_tick_amisha,
    output logic                    min_tick_amisha,
`endif
    output logic [1:0]              ab_amisha
);

    qstate_t filt;
    logic    stable;
    logic    init;
    qtrans_t tr;
    logic    acc;
    logic    dec;
    logic    err_hit;

    quad_sync_filt_amisha #(
        .W_amisha        (2),
        .FILT_LEN_amisha (FILT_LEN_amisha)
    ) u_filt (
        .clk_amisha    (clk_amisha),
        .reset_amisha  (reset_amisha),
        .din_amisha    ({a_amisha, b_amisha}),
        .dout_amisha   (filt),
        .stable_amisha (stable)
    );

    // acc: a new level is taken; dec: it is also decoded into outputs.
    always_comb begin
        tr      = classify(ab_amisha, filt);
        acc     = stable && (init || (filt != ab_amisha));
        dec     = acc && !init && en_in_amisha;
        err_hit = dec && (tr == TR_ILL);
    end

    always_ff @(posedge clk_amisha) begin
        if (!reset_amisha) begin
            init           <= 1'b1;
            ab_amisha      <= ST_00;
            en_amisha      <= 1'b0;
            err_amisha     <= 1'b0;
            up_amisha      <= 1'b1;
            err_cnt_amisha <= '0;
        end else begin
            en_amisha  <= 1'b0;
            err_amisha <= 1'b0;
            if (acc) begin
                ab_amisha <= filt;
                init      <= 1'b0;
            end
            if (dec) begin
                unique case (tr)
                    TR_UP: begin
                        en_amisha <= 1'b1;
                        up_amisha <= 1'b1;
                    end
                    TR_DOWN: begin
                        en_amisha <= 1'b1;
                        up_amisha <= 1'b0;
                    end
                    TR_ILL:  err_amisha <= 1'b1;
                    default: ;
                endcase
            end
            if (clr_err_amisha)
                err_cnt_amisha <= '0;
            else if (err_hit && (err_cnt_amisha != {ERR_W_amisha{1'b1}}))
                err_cnt_amisha <= err_cnt_amisha + 1'b1;
        end
    end

`ifdef QUAD_POS_CNT_EN
    always_ff @(posedge clk_amisha) begin
        if (!reset_amisha)
            pos_amisha <= '0;
        else if (syn_clr_amisha)
            pos_amisha <= '0;
        else if (en_amisha)
            pos_amisha <= up_amisha ? pos_amisha + 1'b1
                                    : pos_amisha - 1'b1;
    end

    assign max_tick_amisha = (pos_amisha == {N_amisha{1'b1}});
    assign min_tick_amisha = (pos_amisha == '0);
`endif

endmodule

// File: tb/tb_quad_step_gen_amisha.sv
// Self-checking bench for quad_step_gen_amisha.
// Sample-window model compared every cycle plus directed literal checks.
module tb_quad_step_gen_amisha;

    localparam int F  = 4;
    localparam int EW = 4;
    localparam int NW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a;
    logic          b;
    logic          en_in;
    logic          clr;
    logic          en;
    logic          up;
    logic          err;
    logic [EW-1:0] cnt;
    logic [1:0]    ab;
`ifdef QUAD_POS_CNT_EN
    logic          syn_clr;
    logic [NW-1:0] pos;
    logic          maxt;
    logic          mint;
`endif

    quad_step_gen_amisha #(
        .FILT_LEN_amisha (F),
        .ERR_W_amisha    (EW),
        .N_amisha        (NW)
    ) dut (
        .clk_amisha      (clk),
        .reset_amisha    (rst_n),
        .a_amisha        (a),
        .b_amisha        (b),
        .en_in_amisha    (en_in),
        .clr_err_amisha  (clr),
        .en_amisha       (en),
        .up_amisha       (up),
        .err_amisha      (err),
        .err_cnt_amisha  (cnt),
`ifdef QUAD_POS_CNT_EN
        .syn_clr_amisha  (syn_clr),
        .pos_amisha      (pos),
        .max_tick_amisha (maxt),
        .min_tick_amisha (mint),
`endif
        .ab_amisha       (ab)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Position of a state along the up sequence 00,01,11,10.
    function automatic int gidx(input logic [1:0] v);
        case (v)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    // Model: keep every pin sample since reset; a level is accepted
    // when the FILT samples taken 3..F+2 edges ago all agree.
    logic [1:0] smp[$];
    bit         started = 0;
    bit         m_init;
    logic [1:0] m_ab;
    bit         m_en;
    bit         m_err;
    bit         m_up;
    int         m_cnt;
    int         m_pos;
    int         n;
    int         d;
    bit         stb;
    logic [1:0] pat;

    always @(posedge clk) begin
        started = 1;
        if (!rst_n) begin
            smp.delete();
            m_init = 1;
            m_ab   = 2'b00;
            m_en   = 0;
            m_err  = 0;
            m_up   = 1;
            m_cnt  = 0;
            m_pos  = 0;
        end else begin
`ifdef QUAD_POS_CNT_EN
            if (syn_clr)
                m_pos = 0;
            else if (m_en)
                m_pos = m_up ? (m_pos + 1) % (2**NW)
                             : (m_pos + 2**NW - 1) % (2**NW);
`endif
            m_en  = 0;
            m_err = 0;
            smp.push_back({a, b});
            n = smp.size() - 1;
            if (n >= F + 2) begin
                pat = smp[n-3];
                stb = 1;
                for (int k = n - F - 2; k <= n - 3; k++)
                    if (smp[k] != pat)
                        stb = 0;
                if (stb && (m_init || pat != m_ab)) begin
                    if (!m_init && en_in) begin
                        d = (gidx(pat) - gidx(m_ab) + 4) % 4;
                        if (d == 1) begin
                            m_en = 1;
                            m_up = 1;
                        end else if (d == 3) begin
                            m_en = 1;
                            m_up = 0;
                        end else begin
                            m_err = 1;
                        end
                    end
                    m_ab   = pat;
                    m_init = 0;
                end
            end
            if (clr)
                m_cnt = 0;
            else if (m_err && m_cnt < 2**EW - 1)
                m_cnt++;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            tests++;
            if ($isunknown({en, up, err, cnt, ab}) ||
                en != m_en || up != m_up || err != m_err ||
                int'(cnt) != m_cnt || ab != m_ab) begin
                fails++;
                $display("FAIL cycle_cmp t=%0t actual en/up/err=%b%b%b cnt=%0d ab=%b required en/up/err=%b%b%b cnt=%0d ab=%b",
                         $time, en, up, err, cnt, ab,
                         m_en, m_up, m_err, m_cnt, m_ab);
            end
`ifdef QUAD_POS_CNT_EN
            tests++;
            if ($isunknown({pos, maxt, mint}) || int'(pos) != m_pos ||
                maxt != (m_pos == 2**NW - 1) || mint != (m_pos == 0)) begin
                fails++;
                $display("FAIL pos_cmp t=%0t actual pos=%0d max=%b min=%b required pos=%0d",
                         $time, pos, maxt, mint, m_pos);
            end
`endif
        end
    end

    task automatic apply(
        input  logic [1:0] p,
        input  int         cyc,
        output int         lat,
        output int         ne,
        output int         nr
    );
        {a, b} = p;
        lat = -1;
        ne  = 0;
        nr  = 0;
        for (int i = 0; i < cyc; i++) begin
            @(posedge clk);
            #1;
            if (en === 1'b1) begin
                ne++;
                if (lat < 0)
                    lat = i;
            end
            if (err === 1'b1)
                nr++;
        end
    endtask

    int         lat;
    int         ne;
    int         nr;
    int         tot;
    logic [1:0] seq_up [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    logic [1:0] seq_dn [4] = '{2'b10, 2'b11, 2'b01, 2'b00};

    initial begin
        rst_n = 1'b0;
        {a, b} = 2'b01;
        en_in = 1'b1;
        clr   = 1'b0;
`ifdef QUAD_POS_CNT_EN
        syn_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_up", int'(up), 1);
        chk("rst_cnt", int'(cnt), 0);
        rst_n = 1'b1;

        // Idle pins at 01: loaded on edge F+2 with no step or error.
        apply(2'b01, F + 2, lat, ne, nr);
        chk("init_ab_early", int'(ab), 0);
        tot = ne + nr;
        apply(2'b01, 1, lat, ne, nr);
        chk("init_ab", int'(ab), 1);
        tot += ne + nr;
        apply(2'b01, 8, lat, ne, nr);
        chk("init_quiet", tot + ne + nr, 0);

        apply(2'b00, 10, lat, ne, nr);
        chk("to00_step", ne, 1);
        chk("to00_dir", int'(up), 0);

        for (int i = 0; i < 4; i++) begin
            apply(seq_up[i], 10, lat, ne, nr);
            chk("up_lat", lat, F + 2);
            chk("up_cnt", ne + 10 * nr, 1);
            chk("up_dir", int'(up), 1);
        end

        for (int i = 0; i < 4; i++) begin
            apply(seq_dn[i], 10, lat, ne, nr);
            chk("dn_lat", lat, 6);
            chk("dn_cnt", ne + 10 * nr, 1);
            chk("dn_dir", int'(up), 0);
        end

        apply(2'b11, 10, lat, ne, nr);
        chk("ill_err", nr, 1);
        chk("ill_noen", ne, 0);
        chk("ill_cnt", int'(cnt), 1);
        chk("ill_dir", int'(up), 0);
        tot = 0;
        for (int k = 0; k < 19; k++) begin
            apply((k % 2 == 0) ? 2'b00 : 2'b11, 10, lat, ne, nr);
            tot += nr + 100 * ne;
        end
        chk("ill_19", tot, 19);
        chk("ill_sat", int'(cnt), 15);

        // Clear sampled on the same edge that registers the error.
        {a, b} = 2'b11;
        repeat (F + 2) @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        chk("clr_err_pulse", int'(err), 1);
        chk("clr_cnt", int'(cnt), 0);
        apply(2'b11, 5, lat, ne, nr);

        apply(2'b10, 10, lat, ne, nr);
        chk("back_10", ne, 1);
        apply(2'b00, 10, lat, ne, nr);
        chk("back_00", ne, 1);
        chk("back_up", int'(up), 1);

        // Pulse of F-1 samples must be filtered out.
        {a, b} = 2'b01;
        repeat (F - 1) @(posedge clk);
        #1;
        apply(2'b00, 12, lat, ne, nr);
        chk("glitch", ne + nr, 0);
        chk("glitch_ab", int'(ab), 0);

        en_in = 1'b0;
        apply(2'b01, 10, lat, ne, nr);
        chk("dis_noen", ne + nr, 0);
        chk("dis_ab", int'(ab), 1);
        chk("dis_up", int'(up), 1);
        en_in = 1'b1;

        // Reset in the middle of a pending transition.
        {a, b} = 2'b11;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst_ab", int'(ab), 0);
        chk("mid_rst_cnt", int'(cnt), 0);
        rst_n = 1'b1;
        apply(2'b11, 12, lat, ne, nr);
        chk("mid_rst_quiet", ne + nr, 0);
        chk("mid_rst_ab2", int'(ab), 3);
`ifdef QUAD_POS_CNT_EN
        chk("pos_rst", int'(pos), 0);
        chk("pos_min", int'(mint), 1);
`endif

        apply(2'b01, 10, lat, ne, nr);
        chk("pos_dn_step", ne, 1);
        chk("pos_dn_dir", int'(up), 0);
`ifdef QUAD_POS_CNT_EN
        chk("pos_wrap", int'(pos), 255);
        chk("pos_max", int'(maxt), 1);
`endif

        // Position clear lands on the edge that would apply the step.
        {a, b} = 2'b00;
        repeat (F + 3) @(posedge clk);
        #1;
        chk("clr_step_en", int'(en), 1);
`ifdef QUAD_POS_CNT_EN
        syn_clr = 1'b1;
`endif
        @(posedge clk);
        #1;
`ifdef QUAD_POS_CNT_EN
        syn_clr = 1'b0;
        chk("pos_clr", int'(pos), 0);
`endif
        chk("clr_step_ab", int'(ab), 0);
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
